// File: rtl/wrp_shff_ctrl.sv
// Frame controller for the 16-lane shuffle switch: paces 16-beat blocks into the switch and counts its output beats.
// Optional drain watchdog enabled by defining WRP_SHFF_CTRL_TIMEOUT_EN.
`timescale 1ns/1ps
module wrp_shff_ctrl #(
   parameter int NBLK_W  = 16,
   parameter int TMO_CYC = 64
) (
   input  logic              clk,
   input  logic              srst_n,
   input  logic              cmd_start_i,
   input  logic [NBLK_W-1:0] cmd_nblk_i,
   input  logic              s_vld_i,
   output logic              s_rdy_o,
   output logic              sw_start_o,
   input  logic              sw_vld_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_underrun_o,
   output logic              err_timeout_o,
   output logic [NBLK_W+3:0] out_cnt_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]        state, state_nxt;
   logic [NBLK_W-1:0] nblk_q, blk_left;
   logic [3:0]        beat;
   logic [NBLK_W+3:0] cnt_nxt, cnt_tgt;
   logic              tmo_hit;
   logic              accept;

   assign s_rdy_o = (state == S_WAIT) || (state == S_RUN);
   assign busy_o  = s_rdy_o || (state == S_DRAIN);
   assign done_o  = (state == S_DONE);
   // Beat 0 of a follow-on block sits in RUN so back-to-back blocks need no idle cycle.
   assign sw_start_o = s_vld_i && ((state == S_WAIT) || ((state == S_RUN) && (beat == 4'd0)));
   assign cnt_nxt = out_cnt_o + {{(NBLK_W+3){1'b0}}, (sw_vld_i && busy_o)};
   assign cnt_tgt = {nblk_q, 4'd0};
   assign accept  = (state == S_IDLE) && cmd_start_i && (cmd_nblk_i != '0);

`ifdef WRP_SHFF_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TMO_CYC + 1);
   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = (state == S_DRAIN) && !sw_vld_i && (tmo_cnt == TW'(TMO_CYC - 1));

   always_ff @(posedge clk) begin
      if (!srst_n || (state != S_DRAIN) || sw_vld_i) tmo_cnt <= '0;
      else                                           tmo_cnt <= tmo_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!srst_n)                               err_timeout_o <= 1'b0;
      else if (accept)                           err_timeout_o <= 1'b0;
      else if (tmo_hit && (cnt_nxt != cnt_tgt))  err_timeout_o <= 1'b1;
   end
`else
   assign tmo_hit       = 1'b0;
   assign err_timeout_o = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (cmd_start_i) state_nxt = (cmd_nblk_i != '0) ? S_WAIT : S_DONE;
         S_WAIT:  if (s_vld_i) state_nxt = S_RUN;
         S_RUN: begin
            if ((beat == 4'd0) && !s_vld_i)            state_nxt = S_WAIT;
            else if ((beat == 4'd15) && (blk_left == '0)) state_nxt = S_DRAIN;
         end
         S_DRAIN: if ((cnt_nxt == cnt_tgt) || tmo_hit) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         state          <= S_IDLE;
         nblk_q         <= '0;
         blk_left       <= '0;
         beat           <= '0;
         out_cnt_o      <= '0;
         err_underrun_o <= 1'b0;
      end else begin
         state <= state_nxt;
         if ((state == S_IDLE) && cmd_start_i) begin
            nblk_q   <= cmd_nblk_i;
            blk_left <= cmd_nblk_i;
         end else if (sw_start_o) begin
            blk_left <= blk_left - 1'b1;
         end
         if (accept) begin
            out_cnt_o      <= '0;
            err_underrun_o <= 1'b0;
         end else begin
            out_cnt_o <= cnt_nxt;
            if ((state == S_RUN) && (beat != 4'd0) && !s_vld_i) err_underrun_o <= 1'b1;
         end
         // The switch cannot stall, so the beat index free-runs through a block.
         if (sw_start_o)          beat <= 4'd1;
         else if (state == S_RUN) beat <= beat + 4'd1;
      end
   end

endmodule

// File: tb/tb_wrp_shff_ctrl.sv
// Scoreboard bench for wrp_shff_ctrl: directed frames against a fixed-latency switch model.
`timescale 1ns/1ps
module tb_wrp_shff_ctrl;

   localparam int NW  = 8;
   localparam int TMO = 20;

   logic          clk = 1'b0;
   logic          srst_n, cmd_start, s_vld, s_rdy, sw_start, sw_vld;
   logic          busy, done, e_und, e_tmo, sw_en;
   logic [NW-1:0] nblk;
   logic [NW+3:0] out_cnt;
   logic [20:0]   hist;

   typedef struct {int cyc; int cnt; bit chk; bit und; bit tmo;} dn_t;
   int  st_q[$];
   dn_t dn_q[$];
   dn_t mon_e;
   int  total = 0, bad = 0, done_seen = 0, cyc = 0, c0;

   always #5 clk = ~clk;

   wrp_shff_ctrl #(.NBLK_W(NW), .TMO_CYC(TMO)) dut (
      .clk(clk), .srst_n(srst_n), .cmd_start_i(cmd_start), .cmd_nblk_i(nblk),
      .s_vld_i(s_vld), .s_rdy_o(s_rdy), .sw_start_o(sw_start), .sw_vld_i(sw_vld),
      .busy_o(busy), .done_o(done), .err_underrun_o(e_und), .err_timeout_o(e_tmo),
      .out_cnt_o(out_cnt)
   );

   // Switch model: start at cycle t gives 16 valid beats at t+6..t+21.
   always @(posedge clk) begin
      if (!srst_n) hist <= '0;
      else         hist <= {hist[19:0], sw_start};
   end
   assign sw_vld = sw_en && (|hist[20:5]);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_done(input int c, input int n, input bit k, input bit u, input bit t);
      dn_t e;
      e.cyc = c; e.cnt = n; e.chk = k; e.und = u; e.tmo = t;
      dn_q.push_back(e);
   endtask

   task automatic wait_done(input int budget);
      int d0, n;
      d0 = done_seen;
      n  = 0;
      while (done_seen == d0 && n < budget) begin
         step();
         n++;
      end
      if (done_seen == d0) chk("wait_done_budget", n, -1);
   endtask

   always @(negedge clk) begin
      if (sw_start === 1'b1) begin
         if (st_q.size() == 0) chk("unexpected_sw_start", cyc, -1);
         else                  chk("sw_start_cycle", cyc, st_q.pop_front());
      end
      if (done === 1'b1) begin
         done_seen++;
         if (dn_q.size() == 0) chk("unexpected_done", cyc, -1);
         else begin
            mon_e = dn_q.pop_front();
            chk("done_cycle", cyc, mon_e.cyc);
            if (mon_e.chk) begin
               chk("done_out_cnt", int'(out_cnt), mon_e.cnt);
               chk("done_underrun", int'(e_und), int'(mon_e.und));
            end
            chk("done_timeout", int'(e_tmo), int'(mon_e.tmo));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset wins over a simultaneous start
      srst_n = 1'b0; cmd_start = 1'b1; nblk = 8'd3; s_vld = 1'b0; sw_en = 1'b1;
      repeat (2) step();
      chk("rst_busy", busy, 0);
      chk("rst_s_rdy", s_rdy, 0);
      chk("rst_sw_start", sw_start, 0);
      chk("rst_done", done, 0);
      chk("rst_underrun", e_und, 0);
      chk("rst_timeout", e_tmo, 0);
      chk("rst_out_cnt", int'(out_cnt), 0);
      cmd_start = 1'b0; srst_n = 1'b1;
      step();

      // two blocks, input held valid
      c0 = cyc; nblk = 8'd2; s_vld = 1'b1; cmd_start = 1'b1;
      st_q.push_back(c0 + 1); st_q.push_back(c0 + 17);
      push_done(c0 + 39, 32, 1'b1, 1'b0, 1'b0);
      step(); cmd_start = 1'b0;
      repeat (31) step();
      chk("run_s_rdy", s_rdy, 1);
      step();
      chk("drain_s_rdy", s_rdy, 0);
      chk("drain_busy", busy, 1);
      wait_done(40);
      chk("idle_busy", busy, 0);

      // one block, input drops at beat 7
      c0 = cyc; nblk = 8'd1; cmd_start = 1'b1;
      st_q.push_back(c0 + 1);
      push_done(c0 + 23, 16, 1'b1, 1'b1, 1'b0);
      step(); cmd_start = 1'b0;
      repeat (7) step();
      s_vld = 1'b0;
      chk("underrun_before", e_und, 0);
      step(); s_vld = 1'b1;
      chk("underrun_after", e_und, 1);
      wait_done(40);

      // three blocks, 5-cycle gap after the first
      c0 = cyc; nblk = 8'd3; cmd_start = 1'b1;
      st_q.push_back(c0 + 1); st_q.push_back(c0 + 22); st_q.push_back(c0 + 38);
      push_done(c0 + 60, 48, 1'b1, 1'b0, 1'b0);
      step(); cmd_start = 1'b0;
      repeat (16) step();
      s_vld = 1'b0;
      repeat (2) step();
      chk("gap_s_rdy", s_rdy, 1);
      chk("gap_busy", busy, 1);
      repeat (3) step();
      s_vld = 1'b1;
      wait_done(80);

      // empty frame
      c0 = cyc; nblk = 8'd0; cmd_start = 1'b1;
      push_done(c0 + 1, 0, 1'b0, 1'b0, 1'b0);
      step(); cmd_start = 1'b0;
      wait_done(5);

      // reset at beat 10, then a clean frame
      c0 = cyc; nblk = 8'd2; cmd_start = 1'b1;
      st_q.push_back(c0 + 1);
      step(); cmd_start = 1'b0;
      repeat (10) step();
      srst_n = 1'b0;
      step();
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_s_rdy", s_rdy, 0);
      chk("mid_rst_sw_start", sw_start, 0);
      chk("mid_rst_out_cnt", int'(out_cnt), 0);
      chk("mid_rst_done", done, 0);
      srst_n = 1'b1;
      step();
      c0 = cyc; nblk = 8'd1; cmd_start = 1'b1;
      st_q.push_back(c0 + 1);
      push_done(c0 + 23, 16, 1'b1, 1'b0, 1'b0);
      step(); cmd_start = 1'b0;
      wait_done(40);

`ifdef WRP_SHFF_CTRL_TIMEOUT_EN
      // switch withholds its output: watchdog ends the frame
      sw_en = 1'b0;
      c0 = cyc; nblk = 8'd1; cmd_start = 1'b1;
      st_q.push_back(c0 + 1);
      push_done(c0 + 17 + TMO, 0, 1'b1, 1'b0, 1'b1);
      step(); cmd_start = 1'b0;
      wait_done(100);
      sw_en = 1'b1;
`endif

      step();
      chk("start_queue_drained", st_q.size(), 0);
      chk("done_queue_drained", dn_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wrp_shff_ctrl.md
WRP_SHFF_CTRL -- requirements
Module: wrp_shff_ctrl

Interface
REQ-001 SHALL have parameter NBLK_W, default 16: width of the block-count command.
REQ-002 SHALL have parameter TMO_CYC, default 64: drain watchdog limit, in cycles.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port srst_n, input, 1 bit: synchronous reset, active low.
REQ-005 SHALL have port cmd_start_i, input, 1 bit: one-cycle request to process a frame.
REQ-006 SHALL have port cmd_nblk_i, input, NBLK_W bits: number of 16-beat blocks in the frame, sampled on an accepted cmd_start_i.
REQ-007 SHALL have port s_vld_i, input, 1 bit: upstream beat valid (16 lanes, carried outside this block).
REQ-008 SHALL have port s_rdy_o, output, 1 bit: upstream beat accept.
REQ-009 SHALL have port sw_start_o, output, 1 bit: drives the switch network start_i.
REQ-010 SHALL have port sw_vld_i, input, 1 bit: the switch network vld_o.
REQ-011 SHALL have port busy_o, output, 1 bit: a frame is in progress.
REQ-012 SHALL have port done_o, output, 1 bit: one-cycle frame-complete pulse.
REQ-013 SHALL have port err_underrun_o, output, 1 bit: sticky flag, s_vld_i low inside a block.
REQ-014 SHALL have port err_timeout_o, output, 1 bit: sticky drain-watchdog flag.
REQ-015 SHALL have port out_cnt_o, output, NBLK_W+4 bits: output beats counted in the current frame.

Function
REQ-016 SHALL implement the states IDLE, WAIT, RUN, DRAIN and DONE.
REQ-017 IDLE: on cmd_start_i with nblk>0, SHALL latch nblk, clear both error flags and out_cnt_o, and go to WAIT.
REQ-018 IDLE: on cmd_start_i with nblk=0, SHALL go to DONE with no sw_start_o issued.
REQ-019 cmd_start_i SHALL be ignored in every state other than IDLE.
REQ-020 WAIT: s_rdy_o SHALL be 1; when s_vld_i=1, SHALL assert sw_start_o combinationally in that same cycle, set beat index to 1, and go to RUN.
REQ-021 RUN: s_rdy_o SHALL be 1; the beat index SHALL advance every cycle regardless of s_vld_i, because the switch network cannot stall.
REQ-022 RUN: s_vld_i=0 at beat index 1..15 SHALL set err_underrun_o; the block continues.
REQ-023 RUN at beat 15, blocks remaining: if s_vld_i=1 the next cycle SHALL be beat 0 of the next block, with sw_start_o asserted back-to-back; otherwise go to WAIT.
REQ-024 RUN at beat 15 of the last block: SHALL go to DRAIN with s_rdy_o=0 from the next cycle.
REQ-025 s_rdy_o SHALL be 0 in IDLE, DRAIN and DONE.
REQ-026 out_cnt_o SHALL increment on every sw_vld_i=1 cycle while busy_o=1, and SHALL wrap modulo 2^(NBLK_W+4).
REQ-027 DRAIN: when out_cnt_o reaches nblk*16, SHALL go to DONE.
REQ-028 DONE SHALL last one cycle with done_o=1, then go to IDLE.
REQ-029 busy_o SHALL be 1 in WAIT, RUN and DRAIN.
REQ-030 The expected switch latency SHALL be sw_start_o at cycle t giving the first sw_vld_i at t+6, followed by 16 consecutive beats.

Reset
REQ-031 srst_n=0 SHALL force state IDLE, and SHALL force s_rdy_o, sw_start_o, busy_o, done_o, both error flags and out_cnt_o to 0 on the next edge.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no done_o pulse.
REQ-033 srst_n=0 SHALL take priority over cmd_start_i in the same cycle.

Configuration
REQ-034 With WRP_SHFF_CTRL_TIMEOUT_EN defined: in DRAIN, TMO_CYC consecutive cycles with sw_vld_i=0 SHALL set err_timeout_o and go to DONE (done_o still pulses).
REQ-035 Without WRP_SHFF_CTRL_TIMEOUT_EN: err_timeout_o SHALL be tied 0, no watchdog counter SHALL exist, and DRAIN SHALL wait indefinitely.

Verification
REQ-036 Scenario: nblk=2, s_vld_i held 1 -> sw_start_o at beats 0 and 16, err_underrun_o=0, 32 sw_vld_i beats, done_o 1 cycle after the 32nd beat.
REQ-037 Scenario: nblk=1, s_vld_i dropped at beat 7 -> err_underrun_o=1 from the next cycle, block completes, done_o pulses.
REQ-038 Scenario: nblk=3 with a 5-cycle s_vld_i gap between blocks 1 and 2 -> WAIT holds; the second sw_start_o coincides with s_vld_i returning.
REQ-039 Scenario: nblk=0 -> done_o exactly 1 cycle after cmd_start_i, sw_start_o never asserted.
REQ-040 Scenario: srst_n pulsed low at beat 10 of a frame -> all outputs 0; a following cmd_start_i runs a clean frame.
REQ-041 Scenario (TIMEOUT_EN): switch model withholds sw_vld_i -> err_timeout_o=1 and done_o pulse TMO_CYC cycles after DRAIN entry.
